// File: rtl/coreriscv_axi4_client_acquire_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : coreriscv_axi4_client_acquire_arbiter_if
// Purpose  : Bundle of TileLink uncached channels around the two-client
//            acquire arbiter: two inner requester ports (acquire in,
//            grant out, finish in) and one outer client port (acquire out,
//            grant in, finish out).
// Modports : slave  - the arbiter side (takes inner requests, drives outer)
//            master - the environment side (requesters + outer manager)
// Ports    : NBEATS sets the addr_beat width ($clog2(NBEATS) bits).
// Revision : 1.0 - initial release
// ============================================================================
interface coreriscv_axi4_client_acquire_arbiter_if #(
    parameter int NBEATS = 8
);
    localparam int c_beat_w = $clog2(NBEATS);

    // ---------------- inner port 0 ----------------
    logic                io_in0_acquire_ready;
    logic                io_in0_acquire_valid;
    logic [25:0]         io_in0_acquire_bits_addr_block;
    logic [0:0]          io_in0_acquire_bits_client_xact_id;
    logic [c_beat_w-1:0] io_in0_acquire_bits_addr_beat;
    logic                io_in0_acquire_bits_is_builtin_type;
    logic [2:0]          io_in0_acquire_bits_a_type;
    logic [11:0]         io_in0_acquire_bits_union;
    logic [63:0]         io_in0_acquire_bits_data;

    logic                io_in0_grant_ready;
    logic                io_in0_grant_valid;
    logic [c_beat_w-1:0] io_in0_grant_bits_addr_beat;
    logic [0:0]          io_in0_grant_bits_client_xact_id;
    logic                io_in0_grant_bits_manager_xact_id;
    logic                io_in0_grant_bits_is_builtin_type;
    logic [3:0]          io_in0_grant_bits_g_type;
    logic [63:0]         io_in0_grant_bits_data;
    logic                io_in0_grant_bits_manager_id;

    logic                io_in0_finish_ready;
    logic                io_in0_finish_valid;
    logic                io_in0_finish_bits_manager_xact_id;
    logic                io_in0_finish_bits_manager_id;

    // ---------------- inner port 1 ----------------
    logic                io_in1_acquire_ready;
    logic                io_in1_acquire_valid;
    logic [25:0]         io_in1_acquire_bits_addr_block;
    logic [0:0]          io_in1_acquire_bits_client_xact_id;
    logic [c_beat_w-1:0] io_in1_acquire_bits_addr_beat;
    logic                io_in1_acquire_bits_is_builtin_type;
    logic [2:0]          io_in1_acquire_bits_a_type;
    logic [11:0]         io_in1_acquire_bits_union;
    logic [63:0]         io_in1_acquire_bits_data;

    logic                io_in1_grant_ready;
    logic                io_in1_grant_valid;
    logic [c_beat_w-1:0] io_in1_grant_bits_addr_beat;
    logic [0:0]          io_in1_grant_bits_client_xact_id;
    logic                io_in1_grant_bits_manager_xact_id;
    logic                io_in1_grant_bits_is_builtin_type;
    logic [3:0]          io_in1_grant_bits_g_type;
    logic [63:0]         io_in1_grant_bits_data;
    logic                io_in1_grant_bits_manager_id;

    logic                io_in1_finish_ready;
    logic                io_in1_finish_valid;
    logic                io_in1_finish_bits_manager_xact_id;
    logic                io_in1_finish_bits_manager_id;

    // ---------------- outer client port ----------------
    logic                io_outer_acquire_ready;
    logic                io_outer_acquire_valid;
    logic [25:0]         io_outer_acquire_bits_addr_block;
    logic [1:0]          io_outer_acquire_bits_client_xact_id;
    logic [c_beat_w-1:0] io_outer_acquire_bits_addr_beat;
    logic                io_outer_acquire_bits_is_builtin_type;
    logic [2:0]          io_outer_acquire_bits_a_type;
    logic [11:0]         io_outer_acquire_bits_union;
    logic [63:0]         io_outer_acquire_bits_data;

    logic                io_outer_grant_ready;
    logic                io_outer_grant_valid;
    logic [c_beat_w-1:0] io_outer_grant_bits_addr_beat;
    logic [1:0]          io_outer_grant_bits_client_xact_id;
    logic                io_outer_grant_bits_manager_xact_id;
    logic                io_outer_grant_bits_is_builtin_type;
    logic [3:0]          io_outer_grant_bits_g_type;
    logic [63:0]         io_outer_grant_bits_data;
    logic                io_outer_grant_bits_manager_id;

    logic                io_outer_finish_ready;
    logic                io_outer_finish_valid;
    logic                io_outer_finish_bits_manager_xact_id;
    logic                io_outer_finish_bits_manager_id;

    modport slave (
        output io_in0_acquire_ready,
        input  io_in0_acquire_valid, io_in0_acquire_bits_addr_block,
               io_in0_acquire_bits_client_xact_id, io_in0_acquire_bits_addr_beat,
               io_in0_acquire_bits_is_builtin_type, io_in0_acquire_bits_a_type,
               io_in0_acquire_bits_union, io_in0_acquire_bits_data,
        input  io_in0_grant_ready,
        output io_in0_grant_valid, io_in0_grant_bits_addr_beat,
               io_in0_grant_bits_client_xact_id, io_in0_grant_bits_manager_xact_id,
               io_in0_grant_bits_is_builtin_type, io_in0_grant_bits_g_type,
               io_in0_grant_bits_data, io_in0_grant_bits_manager_id,
        output io_in0_finish_ready,
        input  io_in0_finish_valid, io_in0_finish_bits_manager_xact_id,
               io_in0_finish_bits_manager_id,

        output io_in1_acquire_ready,
        input  io_in1_acquire_valid, io_in1_acquire_bits_addr_block,
               io_in1_acquire_bits_client_xact_id, io_in1_acquire_bits_addr_beat,
               io_in1_acquire_bits_is_builtin_type, io_in1_acquire_bits_a_type,
               io_in1_acquire_bits_union, io_in1_acquire_bits_data,
        input  io_in1_grant_ready,
        output io_in1_grant_valid, io_in1_grant_bits_addr_beat,
               io_in1_grant_bits_client_xact_id, io_in1_grant_bits_manager_xact_id,
               io_in1_grant_bits_is_builtin_type, io_in1_grant_bits_g_type,
               io_in1_grant_bits_data, io_in1_grant_bits_manager_id,
        output io_in1_finish_ready,
        input  io_in1_finish_valid, io_in1_finish_bits_manager_xact_id,
               io_in1_finish_bits_manager_id,

        input  io_outer_acquire_ready,
        output io_outer_acquire_valid, io_outer_acquire_bits_addr_block,
               io_outer_acquire_bits_client_xact_id, io_outer_acquire_bits_addr_beat,
               io_outer_acquire_bits_is_builtin_type, io_outer_acquire_bits_a_type,
               io_outer_acquire_bits_union, io_outer_acquire_bits_data,
        output io_outer_grant_ready,
        input  io_outer_grant_valid, io_outer_grant_bits_addr_beat,
               io_outer_grant_bits_client_xact_id, io_outer_grant_bits_manager_xact_id,
               io_outer_grant_bits_is_builtin_type, io_outer_grant_bits_g_type,
               io_outer_grant_bits_data, io_outer_grant_bits_manager_id,
        input  io_outer_finish_ready,
        output io_outer_finish_valid, io_outer_finish_bits_manager_xact_id,
               io_outer_finish_bits_manager_id
    );

    modport master (
        input  io_in0_acquire_ready,
        output io_in0_acquire_valid, io_in0_acquire_bits_addr_block,
               io_in0_acquire_bits_client_xact_id, io_in0_acquire_bits_addr_beat,
               io_in0_acquire_bits_is_builtin_type, io_in0_acquire_bits_a_type,
               io_in0_acquire_bits_union, io_in0_acquire_bits_data,
        output io_in0_grant_ready,
        input  io_in0_grant_valid, io_in0_grant_bits_addr_beat,
               io_in0_grant_bits_client_xact_id, io_in0_grant_bits_manager_xact_id,
               io_in0_grant_bits_is_builtin_type, io_in0_grant_bits_g_type,
               io_in0_grant_bits_data, io_in0_grant_bits_manager_id,
        input  io_in0_finish_ready,
        output io_in0_finish_valid, io_in0_finish_bits_manager_xact_id,
               io_in0_finish_bits_manager_id,

        input  io_in1_acquire_ready,
        output io_in1_acquire_valid, io_in1_acquire_bits_addr_block,
               io_in1_acquire_bits_client_xact_id, io_in1_acquire_bits_addr_beat,
               io_in1_acquire_bits_is_builtin_type, io_in1_acquire_bits_a_type,
               io_in1_acquire_bits_union, io_in1_acquire_bits_data,
        output io_in1_grant_ready,
        input  io_in1_grant_valid, io_in1_grant_bits_addr_beat,
               io_in1_grant_bits_client_xact_id, io_in1_grant_bits_manager_xact_id,
               io_in1_grant_bits_is_builtin_type, io_in1_grant_bits_g_type,
               io_in1_grant_bits_data, io_in1_grant_bits_manager_id,
        input  io_in1_finish_ready,
        output io_in1_finish_valid, io_in1_finish_bits_manager_xact_id,
               io_in1_finish_bits_manager_id,

        output io_outer_acquire_ready,
        input  io_outer_acquire_valid, io_outer_acquire_bits_addr_block,
               io_outer_acquire_bits_client_xact_id, io_outer_acquire_bits_addr_beat,
               io_outer_acquire_bits_is_builtin_type, io_outer_acquire_bits_a_type,
               io_outer_acquire_bits_union, io_outer_acquire_bits_data,
        input  io_outer_grant_ready,
        output io_outer_grant_valid, io_outer_grant_bits_addr_beat,
               io_outer_grant_bits_client_xact_id, io_outer_grant_bits_manager_xact_id,
               io_outer_grant_bits_is_builtin_type, io_outer_grant_bits_g_type,
               io_outer_grant_bits_data, io_outer_grant_bits_manager_id,
        output io_outer_finish_ready,
        input  io_outer_finish_valid, io_outer_finish_bits_manager_xact_id,
               io_outer_finish_bits_manager_id
    );
endinterface
`default_nettype wire

// File: rtl/coreriscv_axi4_client_acquire_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : coreriscv_axi4_client_acquire_arbiter
// Purpose  : Shares one outer TileLink client port between two inner
//            requesters. Acquires are arbitrated round-robin, with
//            multi-beat putBlocks locked to their port until the last beat.
//            The winning port index is prepended to client_xact_id so that
//            grants can be steered back; finishes merge with port 0 first.
// Ports    : clk   - single clock, rising edge
//            reset - synchronous, active-high; gates every valid/ready output
//            bus   - channel bundle (slave modport): inner acquire/grant/
//                    finish for ports 0 and 1, outer acquire/grant/finish
// Revision : 1.0 - initial release
// ============================================================================
module coreriscv_axi4_client_acquire_arbiter #(
    parameter int NBEATS = 8
) (
    input  logic clk,
    input  logic reset,
    coreriscv_axi4_client_acquire_arbiter_if.slave bus
);

    localparam int                  c_beat_w        = $clog2(NBEATS);
    localparam logic [c_beat_w-1:0] c_last_beat     = c_beat_w'(NBEATS - 1);
    localparam logic [c_beat_w-1:0] c_first_beat    = c_beat_w'(1);
    localparam logic [2:0]          c_put_block     = 3'd3;

    // ------------------------------------------------------------------
    // Arbitration state
    // ------------------------------------------------------------------
    logic                r_last_port;
    logic                r_locked;
    logic                r_lock_port;
    logic [c_beat_w-1:0] r_beat_cnt;

    // ------------------------------------------------------------------
    // Acquire selection. sel depends only on state and the inner valids,
    // never on outer ready, so a stalled beat keeps its port and no
    // ready->valid loop can form through the arbiter.
    // ------------------------------------------------------------------
    logic                w_sel;
    logic                w_sel_valid;
    logic                w_sel_multi;
    logic                w_acq_fire;

    always_comb begin
        w_sel = 1'b0;
        if (r_locked) begin
            w_sel = r_lock_port;
        end else if (bus.io_in0_acquire_valid && bus.io_in1_acquire_valid) begin
            w_sel = ~r_last_port;
        end else if (bus.io_in1_acquire_valid) begin
            w_sel = 1'b1;
        end
    end

    always_comb begin
        w_sel_valid = bus.io_in0_acquire_valid;
        bus.io_outer_acquire_bits_addr_block      = bus.io_in0_acquire_bits_addr_block;
        bus.io_outer_acquire_bits_client_xact_id  = {1'b0, bus.io_in0_acquire_bits_client_xact_id};
        bus.io_outer_acquire_bits_addr_beat       = bus.io_in0_acquire_bits_addr_beat;
        bus.io_outer_acquire_bits_is_builtin_type = bus.io_in0_acquire_bits_is_builtin_type;
        bus.io_outer_acquire_bits_a_type          = bus.io_in0_acquire_bits_a_type;
        bus.io_outer_acquire_bits_union           = bus.io_in0_acquire_bits_union;
        bus.io_outer_acquire_bits_data            = bus.io_in0_acquire_bits_data;
        if (w_sel) begin
            w_sel_valid = bus.io_in1_acquire_valid;
            bus.io_outer_acquire_bits_addr_block      = bus.io_in1_acquire_bits_addr_block;
            bus.io_outer_acquire_bits_client_xact_id  = {1'b1, bus.io_in1_acquire_bits_client_xact_id};
            bus.io_outer_acquire_bits_addr_beat       = bus.io_in1_acquire_bits_addr_beat;
            bus.io_outer_acquire_bits_is_builtin_type = bus.io_in1_acquire_bits_is_builtin_type;
            bus.io_outer_acquire_bits_a_type          = bus.io_in1_acquire_bits_a_type;
            bus.io_outer_acquire_bits_union           = bus.io_in1_acquire_bits_union;
            bus.io_outer_acquire_bits_data            = bus.io_in1_acquire_bits_data;
        end
    end

    // Only a built-in putBlock spans several beats; everything else is one.
    assign w_sel_multi = bus.io_outer_acquire_bits_is_builtin_type &&
                         (bus.io_outer_acquire_bits_a_type == c_put_block);

    assign bus.io_outer_acquire_valid = !reset && w_sel_valid;
    assign bus.io_in0_acquire_ready   = !reset && bus.io_outer_acquire_ready && !w_sel;
    assign bus.io_in1_acquire_ready   = !reset && bus.io_outer_acquire_ready &&  w_sel;
    assign w_acq_fire                 = bus.io_outer_acquire_valid && bus.io_outer_acquire_ready;

    // ------------------------------------------------------------------
    // State update. Nothing moves on a stalled beat. The first putBlock
    // beat opens the lock with the counter already at 1, so the lock drops
    // when the counter reaches the last beat index and wraps back to 0.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_port <= 1'b1;
            r_locked    <= 1'b0;
            r_lock_port <= 1'b0;
            r_beat_cnt  <= '0;
        end else if (w_acq_fire) begin
            if (r_locked) begin
                r_beat_cnt <= r_beat_cnt + c_first_beat;
                if (r_beat_cnt == c_last_beat) begin
                    r_locked <= 1'b0;
                end
            end else begin
                r_last_port <= w_sel;
                if (w_sel_multi) begin
                    r_locked    <= 1'b1;
                    r_lock_port <= w_sel;
                    r_beat_cnt  <= c_first_beat;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Grant steering: the top xact_id bit names the requester; grants are
    // stateless and routed beat by beat.
    // ------------------------------------------------------------------
    logic w_grant_dst;

    assign w_grant_dst = bus.io_outer_grant_bits_client_xact_id[1];

    assign bus.io_in0_grant_valid   = !reset && bus.io_outer_grant_valid && !w_grant_dst;
    assign bus.io_in1_grant_valid   = !reset && bus.io_outer_grant_valid &&  w_grant_dst;
    assign bus.io_outer_grant_ready = !reset && (w_grant_dst ? bus.io_in1_grant_ready
                                                             : bus.io_in0_grant_ready);

    assign bus.io_in0_grant_bits_addr_beat       = bus.io_outer_grant_bits_addr_beat;
    assign bus.io_in0_grant_bits_client_xact_id  = bus.io_outer_grant_bits_client_xact_id[0];
    assign bus.io_in0_grant_bits_manager_xact_id = bus.io_outer_grant_bits_manager_xact_id;
    assign bus.io_in0_grant_bits_is_builtin_type = bus.io_outer_grant_bits_is_builtin_type;
    assign bus.io_in0_grant_bits_g_type          = bus.io_outer_grant_bits_g_type;
    assign bus.io_in0_grant_bits_data            = bus.io_outer_grant_bits_data;
    assign bus.io_in0_grant_bits_manager_id      = bus.io_outer_grant_bits_manager_id;

    assign bus.io_in1_grant_bits_addr_beat       = bus.io_outer_grant_bits_addr_beat;
    assign bus.io_in1_grant_bits_client_xact_id  = bus.io_outer_grant_bits_client_xact_id[0];
    assign bus.io_in1_grant_bits_manager_xact_id = bus.io_outer_grant_bits_manager_xact_id;
    assign bus.io_in1_grant_bits_is_builtin_type = bus.io_outer_grant_bits_is_builtin_type;
    assign bus.io_in1_grant_bits_g_type          = bus.io_outer_grant_bits_g_type;
    assign bus.io_in1_grant_bits_data            = bus.io_outer_grant_bits_data;
    assign bus.io_in1_grant_bits_manager_id      = bus.io_outer_grant_bits_manager_id;

    // ------------------------------------------------------------------
    // Finish merge: fixed priority, port 0 first, single beat each.
    // ------------------------------------------------------------------
    assign bus.io_outer_finish_valid = !reset &&
                                       (bus.io_in0_finish_valid || bus.io_in1_finish_valid);
    assign bus.io_outer_finish_bits_manager_xact_id =
        bus.io_in0_finish_valid ? bus.io_in0_finish_bits_manager_xact_id
                                : bus.io_in1_finish_bits_manager_xact_id;
    assign bus.io_outer_finish_bits_manager_id =
        bus.io_in0_finish_valid ? bus.io_in0_finish_bits_manager_id
                                : bus.io_in1_finish_bits_manager_id;
    assign bus.io_in0_finish_ready = !reset && bus.io_outer_finish_ready;
    assign bus.io_in1_finish_ready = !reset && bus.io_outer_finish_ready &&
                                     !bus.io_in0_finish_valid;

endmodule
`default_nettype wire

// File: tb/tb_coreriscv_axi4_client_acquire_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_coreriscv_axi4_client_acquire_arbiter
// Purpose  : Self-checking bench for the two-client acquire arbiter: a table
//            of per-cycle vectors for arbitration/grant/finish, then directed
//            sequences for putBlock locking, mid-burst stall and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coreriscv_axi4_client_acquire_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    coreriscv_axi4_client_acquire_arbiter_if #(.NBEATS(8)) bus ();

    coreriscv_axi4_client_acquire_arbiter #(.NBEATS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [25:0] c_blk0 = 26'h0A0A0A0;
    localparam logic [25:0] c_blk1 = 26'h1B1B1B1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Acquire side drive: put=1 makes a putBlock, else a Get (builtin type 0).
    task automatic drive_acq(input logic v0, input logic v1, input logic put0,
                             input logic put1, input logic [2:0] beat, input logic ordy);
        bus.io_in0_acquire_valid = v0;
        bus.io_in1_acquire_valid = v1;
        bus.io_in0_acquire_bits_a_type = put0 ? 3'd3 : 3'd0;
        bus.io_in1_acquire_bits_a_type = put1 ? 3'd3 : 3'd0;
        bus.io_in0_acquire_bits_addr_beat = beat;
        bus.io_in1_acquire_bits_addr_beat = beat;
        bus.io_outer_acquire_ready = ordy;
    endtask

    task automatic drive_misc(input logic gv, input logic [1:0] gxid, input logic gr0,
                              input logic gr1, input logic fv0, input logic fv1, input logic ofr);
        bus.io_outer_grant_valid = gv;
        bus.io_outer_grant_bits_client_xact_id = gxid;
        bus.io_in0_grant_ready = gr0;
        bus.io_in1_grant_ready = gr1;
        bus.io_in0_finish_valid = fv0;
        bus.io_in1_finish_valid = fv1;
        bus.io_outer_finish_ready = ofr;
    endtask

    function automatic logic [13:0] observe();
        return {bus.io_outer_acquire_valid, bus.io_outer_acquire_bits_client_xact_id,
                bus.io_in0_acquire_ready, bus.io_in1_acquire_ready,
                bus.io_in0_grant_valid, bus.io_in1_grant_valid,
                bus.io_in0_grant_bits_client_xact_id, bus.io_outer_grant_ready,
                bus.io_outer_finish_valid, bus.io_in0_finish_ready, bus.io_in1_finish_ready,
                bus.io_outer_finish_bits_manager_xact_id, bus.io_outer_finish_bits_manager_id};
    endfunction

    function automatic logic [8:0] handshakes();
        return {bus.io_in0_acquire_ready, bus.io_in1_acquire_ready, bus.io_outer_acquire_valid,
                bus.io_in0_grant_valid, bus.io_in1_grant_valid, bus.io_outer_grant_ready,
                bus.io_in0_finish_ready, bus.io_in1_finish_ready, bus.io_outer_finish_valid};
    endfunction

    // Acquire check: expected winning port and ready pair.
    task automatic check_acq(input string name, input logic sel, input logic ar0, input logic ar1);
        check({name, ".xid"}, 64'(bus.io_outer_acquire_bits_client_xact_id), 64'({sel, ~sel}));
        check({name, ".rdy"}, 64'({bus.io_in0_acquire_ready, bus.io_in1_acquire_ready}),
              64'({ar0, ar1}));
    endtask

    typedef struct packed {
        logic v0, v1, ordy;
        logic gv;
        logic [1:0] gxid;
        logic gr0, gr1, fv0, fv1, ofr;
        // {ovalid, oxid[1:0], ar0, ar1, gv0, gv1, g0xid, ogr, ofv, fr0, fr1, fbits[1:0]}
        logic [13:0] exp;
    } vec_t;

    vec_t vecs [11];

    initial begin
        // In0 uses inner xid 1, in1 uses inner xid 0: outer xid reads 01 for
        // port 0 and 10 for port 1. Finish bits {mxid,mid}: port0 01, port1 10.
        vecs[0]  = '{1,1,1, 1,2'b10,1,1, 1,1,1, 14'b1_01_1_0_0_1_0_1_1_1_0_01};
        vecs[1]  = '{1,1,1, 1,2'b01,1,1, 0,1,1, 14'b1_10_0_1_1_0_1_1_1_1_1_10};
        vecs[2]  = '{1,1,1, 1,2'b10,1,0, 1,1,0, 14'b1_01_1_0_0_1_0_0_1_0_0_01};
        vecs[3]  = '{1,1,0, 0,2'b00,0,1, 1,0,1, 14'b1_10_0_0_0_0_0_0_1_1_0_01};
        vecs[4]  = '{1,1,1, 1,2'b11,0,1, 0,0,1, 14'b1_10_0_1_0_1_1_1_0_1_1_10};
        vecs[5]  = '{0,1,1, 0,2'b00,0,0, 0,0,0, 14'b1_10_0_1_0_0_0_0_0_0_0_10};
        vecs[6]  = '{0,1,1, 0,2'b00,0,0, 0,0,0, 14'b1_10_0_1_0_0_0_0_0_0_0_10};
        vecs[7]  = '{1,0,1, 0,2'b00,0,0, 0,0,0, 14'b1_01_1_0_0_0_0_0_0_0_0_10};
        vecs[8]  = '{0,0,1, 0,2'b00,0,0, 0,0,0, 14'b0_01_1_0_0_0_0_0_0_0_0_10};
        vecs[9]  = '{0,1,0, 0,2'b00,0,0, 0,0,0, 14'b1_10_0_0_0_0_0_0_0_0_0_10};
        vecs[10] = '{1,1,1, 0,2'b00,0,0, 0,0,0, 14'b1_10_0_1_0_0_0_0_0_0_0_10};

        // Static payload
        bus.io_in0_acquire_bits_addr_block = c_blk0;
        bus.io_in1_acquire_bits_addr_block = c_blk1;
        bus.io_in0_acquire_bits_client_xact_id = 1'b1;
        bus.io_in1_acquire_bits_client_xact_id = 1'b0;
        bus.io_in0_acquire_bits_is_builtin_type = 1'b1;
        bus.io_in1_acquire_bits_is_builtin_type = 1'b1;
        bus.io_in0_acquire_bits_union = 12'h111;
        bus.io_in1_acquire_bits_union = 12'h222;
        bus.io_in0_acquire_bits_data = 64'h0000_0000_DEAD_0000;
        bus.io_in1_acquire_bits_data = 64'h0000_0000_0000_BEEF;
        bus.io_in0_finish_bits_manager_xact_id = 1'b0;
        bus.io_in0_finish_bits_manager_id = 1'b1;
        bus.io_in1_finish_bits_manager_xact_id = 1'b1;
        bus.io_in1_finish_bits_manager_id = 1'b0;
        bus.io_outer_grant_bits_addr_beat = 3'd5;
        bus.io_outer_grant_bits_manager_xact_id = 1'b1;
        bus.io_outer_grant_bits_is_builtin_type = 1'b1;
        bus.io_outer_grant_bits_g_type = 4'h5;
        bus.io_outer_grant_bits_data = 64'h0123_4567_89AB_CDEF;
        bus.io_outer_grant_bits_manager_id = 1'b1;

        // Reset with every input active: all handshakes held low.
        reset = 1'b1;
        drive_acq(1, 1, 0, 0, 3'd0, 1);
        drive_misc(1, 2'b10, 1, 1, 1, 1, 1);
        @(negedge clk); #2;
        check("reset_outputs", 64'(handshakes()), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven vectors, one per cycle, state carried forward.
        for (int i = 0; i < 11; i++) begin
            if (i > 0) @(negedge clk);
            drive_acq(vecs[i].v0, vecs[i].v1, 0, 0, 3'd0, vecs[i].ordy);
            drive_misc(vecs[i].gv, vecs[i].gxid, vecs[i].gr0, vecs[i].gr1,
                       vecs[i].fv0, vecs[i].fv1, vecs[i].ofr);
            #2;
            check($sformatf("vec%0d", i), 64'(observe()), 64'(vecs[i].exp));
            if (i == 4) begin
                check("grant_data_in1", bus.io_in1_grant_bits_data, 64'h0123_4567_89AB_CDEF);
                check("grant_gtype_in1", 64'(bus.io_in1_grant_bits_g_type), 64'h5);
            end
        end
        drive_misc(0, 2'b00, 0, 0, 0, 0, 0);

        // putBlock from port 0 with port 1 continuously valid.
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            drive_acq(1, 1, 1, 0, 3'(b), 1);
            #2;
            check_acq($sformatf("put_beat%0d", b), 0, 1, 0);
            check($sformatf("put_addr_beat%0d", b),
                  64'(bus.io_outer_acquire_bits_addr_beat), 64'(b));
            if (b == 0) begin
                check("put_blk0", 64'(bus.io_outer_acquire_bits_addr_block), 64'(c_blk0));
                check("put_atype", 64'(bus.io_outer_acquire_bits_a_type), 64'd3);
            end
        end
        @(negedge clk);
        drive_acq(1, 1, 0, 0, 3'd0, 1);
        #2;
        check_acq("put_reopen", 1, 0, 1);
        check("put_reopen_blk1", 64'(bus.io_outer_acquire_bits_addr_block), 64'(c_blk1));

        // putBlock with a 3-cycle outer stall after beat 4.
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            drive_acq(1, 1, 1, 0, 3'd0, !(c >= 4 && c < 7));
            #2;
            if (c >= 4 && c < 7) check_acq($sformatf("stall%0d", c), 0, 0, 0);
            else                 check_acq($sformatf("stall_beat%0d", c), 0, 1, 0);
        end
        @(negedge clk);
        check("stall_beat_cnt", 64'(dut.r_beat_cnt), 64'd0);
        drive_acq(1, 1, 0, 0, 3'd0, 1);
        #2;
        check_acq("stall_reopen", 1, 0, 1);

        // Reset after beat 3 of a putBlock.
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            drive_acq(1, 1, 1, 0, 3'(b), 1);
            #2;
            check_acq($sformatf("rst_beat%0d", b), 0, 1, 0);
        end
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            reset = 1'b1;
            drive_misc(1, 2'b01, 1, 1, 1, 1, 1);
            #2;
            check($sformatf("rst_hold%0d", r), 64'(handshakes()), 64'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        drive_misc(0, 2'b00, 0, 0, 0, 0, 0);
        drive_acq(1, 1, 0, 0, 3'd0, 1);
        #2;
        check_acq("post_rst_first", 0, 1, 0);
        @(negedge clk);
        #2;
        check_acq("post_rst_second", 1, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
